// File: rtl/ram_pkg.sv
// Shared types and default geometry for the single-port RAM request controller.
package ram_pkg;

  localparam int unsigned RAM_AW    = 10;
  localparam int unsigned RAM_DW    = 8;
  localparam int unsigned RAM_DEPTH = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RCAP,
    RESP,
    FILL
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// Request-side controller for a 1-cycle-latency synchronous single-port RAM:
// single read/write requests with a response handshake, plus a bulk fill.
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned AW    = RAM_AW,
  parameter int unsigned DW    = RAM_DW,
  parameter int unsigned DEPTH = RAM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  output logic          fill_done,
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_mode,
  output logic          ram_bi_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // One extra bit so the terminal compare against DEPTH-1 never wraps.
  localparam int unsigned CW = AW + 1;

  ram_ctrl_state_t state_q, next_state;

  logic          rdy_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] fill_q;
  logic [CW-1:0] cnt_q;
  logic          fill_last;
  logic          accept;
  logic          fill_go;

  assign fill_last = (cnt_q == CW'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and RAM-side decode.
  always_comb begin
    next_state = state_q;
    accept     = 1'b0;
    fill_go    = 1'b0;
    ram_cs     = 1'b0;
    ram_mode   = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          fill_go    = 1'b1;
          next_state = FILL;
        end else if (req_valid && rdy_q) begin
          accept     = 1'b1;
          next_state = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        ram_cs     = 1'b1;
        ram_mode   = 1'b1;
        ram_addr   = addr_q;
        ram_wdata  = wdata_q;
        next_state = IDLE;
      end
      READ: begin
        ram_cs     = 1'b1;
        ram_addr   = addr_q;
        next_state = RCAP;
      end
      RCAP: begin
        // Keep the read asserted so the RAM output is still valid at capture.
        ram_cs     = 1'b1;
        ram_addr   = addr_q;
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      FILL: begin
        ram_cs    = 1'b1;
        ram_mode  = 1'b1;
        ram_addr  = cnt_q[AW-1:0];
        ram_wdata = fill_q;
        if (fill_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request/fill latches, fill counter, response data and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      fill_done <= 1'b0;
    end else begin
      rdy_q     <= (next_state == IDLE);
      fill_done <= (state_q == FILL) && fill_last;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (fill_go) begin
        fill_q <= fill_value;
        cnt_q  <= '0;
      end else if (state_q == FILL) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == RCAP) begin
        rsp_rdata <= ram_rdata;
      end
    end
  end

  // A coincident fill_start withdraws ready so no request is taken that cycle.
  assign req_ready = rdy_q & ~fill_start;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign ram_bi_en = ram_mode;

endmodule
